// File: rtl/mfp_irq_pkg.sv
// Shared constants for the MFP-style vectored interrupt controller:
// register indices, VR bit positions and the default spurious vector.
package mfp_irq_pkg;

  localparam logic [2:0] REG_IER  = 3'd0;
  localparam logic [2:0] REG_IPR  = 3'd1;
  localparam logic [2:0] REG_ISR  = 3'd2;
  localparam logic [2:0] REG_IMR  = 3'd3;
  localparam logic [2:0] REG_AER  = 3'd4;
  localparam logic [2:0] REG_LVL  = 3'd5;
  localparam logic [2:0] REG_VR   = 3'd6;
  localparam logic [2:0] REG_STAT = 3'd7;

  localparam int VR_S_BIT = 3;

  localparam logic [7:0] DEF_SPURIOUS_VEC = 8'h18;

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mfp_prio_enc.sv
// Combinational priority encoder: reports the highest set bit of vec.
// idx is 0 when nothing is set; valid tells the two cases apart.
module mfp_prio_enc #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        valid = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/mfp_irq_ctrl.sv
// MFP-style vectored interrupt controller: source conditioning, IER/IPR/ISR/IMR
// state behind a byte-banked CPU port, nested priority irq and iack vectoring.
module mfp_irq_ctrl
  import mfp_irq_pkg::*;
#(
  parameter int         NUM_IRQ      = 16,
  parameter int         IDX_W        = idx_width(NUM_IRQ),
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] SPURIOUS_VEC = DEF_SPURIOUS_VEC
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         din,
  input  logic               sel,
  input  logic [4:0]         addr,
  input  logic               ds,
  input  logic               rw,
  output logic [7:0]         dout,
  output logic               irq,
  input  logic               iack,
  input  logic [NUM_IRQ-1:0] irq_in
);

  localparam int NB = NUM_IRQ / 8;

  logic [NUM_IRQ-1:0] ier, ipr, isr, imr, aer, lvl;
  logic [7:0]         vr, vec_lat;
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] s_d;
  logic               iack_d, iack_arm;

  logic [2:0]         reg_sel;
  logic [1:0]         bank;
  logic               wr_en, rd_en, vr_wr;
  logic [NUM_IRQ-1:0] wmask, wdata;

  assign reg_sel = addr[4:2];
  assign bank    = addr[1:0];
  assign wr_en   = sel & ~ds & ~rw;
  assign rd_en   = sel & ~ds & rw;
  assign vr_wr   = wr_en && reg_sel == REG_VR && bank == 2'd0;
  assign wdata   = {NB{din}};

  // Banks beyond the implemented width leave wmask empty, so writes vanish.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < NB; b++) begin
      if (bank == 2'(b)) wmask[8*b +: 8] = 8'hFF;
    end
  end

  function automatic logic [7:0] bank_byte(input logic [NUM_IRQ-1:0] v,
                                           input logic [1:0] b_sel);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < NB; b++) begin
      if (b_sel == 2'(b)) r = v[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [NUM_IRQ-1:0] merge(input logic [NUM_IRQ-1:0] old,
                                               input logic en,
                                               input logic [NUM_IRQ-1:0] m,
                                               input logic [NUM_IRQ-1:0] d);
    return en ? ((old & ~m) | (d & m)) : old;
  endfunction

  logic [NUM_IRQ-1:0] pend;
  logic               p_valid, s_valid;
  logic [IDX_W-1:0]   p_idx, s_idx;

  assign pend = ipr & imr;

  mfp_prio_enc #(.N(NUM_IRQ), .W(IDX_W)) u_pend_enc (
    .vec   (pend),
    .valid (p_valid),
    .idx   (p_idx)
  );

  mfp_prio_enc #(.N(NUM_IRQ), .W(IDX_W)) u_isr_enc (
    .vec   (isr),
    .valid (s_valid),
    .idx   (s_idx)
  );

  logic [NUM_IRQ-1:0] s, src_set, p_onehot, ipr_clr, isr_clr, isr_set;
  logic               iack_rise, irq_next;

  assign s        = sync_q[SYNC_STAGES-1] ^ aer;
  assign src_set  = ier & ((s & ~s_d & ~lvl) | (s & lvl));
  assign p_onehot = p_valid ? (NUM_IRQ'(1) << p_idx) : '0;
  assign irq_next = p_valid && (!s_valid || p_idx > s_idx);

  // iack handshake: one acknowledge per low-to-high transition of iack; the
  // vector latched on that edge is held on dout until iack drops. iack_arm
  // requires iack to be seen low after reset so a held iack is not re-acked.
  assign iack_rise = iack & ~iack_d & iack_arm;

  always_comb begin
    ipr_clr = '0;
    if (wr_en && (reg_sel == REG_IER || reg_sel == REG_IPR)) ipr_clr = wmask & ~wdata;
    if (iack_rise) ipr_clr = ipr_clr | p_onehot;
    isr_clr = '0;
    if (wr_en && reg_sel == REG_ISR) isr_clr = wmask & ~wdata;
    if (vr_wr && !din[VR_S_BIT]) isr_clr = '1;
    isr_set = (iack_rise && vr[VR_S_BIT]) ? p_onehot : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ier      <= '0;
      ipr      <= '0;
      isr      <= '0;
      imr      <= '0;
      aer      <= '0;
      lvl      <= '0;
      vr       <= '0;
      sync_q   <= '0;
      s_d      <= '0;
      vec_lat  <= '0;
      iack_d   <= 1'b0;
      iack_arm <= 1'b0;
      irq      <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], irq_in};
      s_d      <= s;
      iack_d   <= iack;
      iack_arm <= iack_arm | ~iack;
      irq      <= irq_next;
      ier      <= merge(ier, wr_en && reg_sel == REG_IER, wmask, wdata);
      imr      <= merge(imr, wr_en && reg_sel == REG_IMR, wmask, wdata);
      aer      <= merge(aer, wr_en && reg_sel == REG_AER, wmask, wdata);
      lvl      <= merge(lvl, wr_en && reg_sel == REG_LVL, wmask, wdata);
      // Sets win over clears on both pending and in-service bits.
      ipr      <= (ipr & ~ipr_clr) | src_set;
      isr      <= (isr & ~isr_clr) | isr_set;
      if (vr_wr) vr <= din;
      if (iack_rise) vec_lat <= p_valid ? {vr[7:IDX_W], p_idx} : SPURIOUS_VEC;
    end
  end

  logic [7:0] rdata;

  always_comb begin
    rdata = 8'h00;
    case (reg_sel)
      REG_IER:  rdata = bank_byte(ier, bank);
      REG_IPR:  rdata = bank_byte(ipr, bank);
      REG_ISR:  rdata = bank_byte(isr, bank);
      REG_IMR:  rdata = bank_byte(imr, bank);
      REG_AER:  rdata = bank_byte(aer, bank);
      REG_LVL:  rdata = bank_byte(lvl, bank);
      REG_VR:   rdata = (bank == 2'd0) ? vr : 8'h00;
      REG_STAT: rdata = (bank == 2'd0) ? {irq, 2'b00, 5'(p_idx)} : 8'h00;
      default:  rdata = 8'h00;
    endcase
  end

  assign dout = rd_en ? rdata : (iack ? vec_lat : 8'h00);

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Bench for mfp_irq_ctrl: a 16-source and a 32-source instance share the CPU bus;
// register table, priority/nesting, level/edge/AER, iack and reset corner cases.
module tb_mfp_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  din;
  logic        sel, ds, rw, iack;
  logic [4:0]  addr;
  logic [15:0] irq_in;
  logic [31:0] irq_in32;
  logic [7:0]  dout, dout32;
  logic        irq, irq32;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rd16, rd32;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp16;
    logic [7:0] exp32;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  mfp_irq_ctrl #(.NUM_IRQ(16)) dut (
    .clk (clk), .reset_n (reset_n), .din (din), .sel (sel), .addr (addr),
    .ds (ds), .rw (rw), .dout (dout), .irq (irq), .iack (iack), .irq_in (irq_in)
  );

  mfp_irq_ctrl #(.NUM_IRQ(32)) dut32 (
    .clk (clk), .reset_n (reset_n), .din (din), .sel (sel), .addr (addr),
    .ds (ds), .rw (rw), .dout (dout32), .irq (irq32), .iack (iack), .irq_in (irq_in32)
  );

  function automatic logic [4:0] ra(input int r, input int b);
    return 5'(r * 4 + b);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act);
    logic [7:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %02h", name, act);
      return;
    end
    e = exp_q.pop_front();
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, e);
    end
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
    sel = 1'b1; ds = 1'b0; rw = 1'b0; addr = a; din = d;
    @(negedge clk);
    sel = 1'b0; ds = 1'b1; rw = 1'b1; din = 8'h00;
  endtask

  task automatic cpu_read(input logic [4:0] a);
    sel = 1'b1; ds = 1'b0; rw = 1'b1; addr = a;
    #1;
    rd16 = dout;
    rd32 = dout32;
    sel = 1'b0; ds = 1'b1;
  endtask

  task automatic exp_rd(input string name, input logic [4:0] a, input logic [7:0] e);
    exp_q.push_back(e);
    cpu_read(a);
    chk(name, rd16);
  endtask

  task automatic exp_rd32(input string name, input logic [4:0] a, input logic [7:0] e);
    exp_q.push_back(e);
    cpu_read(a);
    chk(name, rd32);
  endtask

  task automatic exp_val(input string name, input logic [7:0] act, input logic [7:0] e);
    exp_q.push_back(e);
    chk(name, act);
  endtask

  task automatic do_reset;
    reset_n = 1'b0; iack = 1'b0; irq_in = '0; irq_in32 = '0;
    sel = 1'b0; ds = 1'b1; rw = 1'b1; addr = '0; din = '0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{5'd0,  8'hA5, 8'hA5, 8'hA5};
    tbl[1] = '{5'd1,  8'h5A, 8'h5A, 8'h5A};
    tbl[2] = '{5'd2,  8'hFF, 8'h00, 8'hFF};
    tbl[3] = '{5'd15, 8'h81, 8'h00, 8'h81};
    tbl[4] = '{5'd12, 8'h3C, 8'h3C, 8'h3C};
    tbl[5] = '{5'd21, 8'h0F, 8'h0F, 8'h0F};
    tbl[6] = '{5'd18, 8'h0F, 8'h00, 8'h0F};
    tbl[7] = '{5'd24, 8'h48, 8'h48, 8'h48};
    tbl[8] = '{5'd25, 8'hFF, 8'h00, 8'h00};
    tbl[9] = '{5'd28, 8'hFF, 8'h00, 8'h00};

    do_reset();

    // reset state
    exp_val("rst_dout", dout, 8'h00);
    exp_val("rst_irq", {7'b0, irq}, 8'h00);
    exp_rd("rst_ier0", ra(0, 0), 8'h00);
    exp_rd("rst_vr", ra(6, 0), 8'h00);
    exp_rd("rst_stat", ra(7, 0), 8'h00);

    // register table
    for (int i = 0; i < 10; i++) begin
      cpu_write(tbl[i].addr, tbl[i].wdata);
      exp_rd($sformatf("tbl16_%0d", i), tbl[i].addr, tbl[i].exp16);
      exp_rd32($sformatf("tbl32_%0d", i), tbl[i].addr, tbl[i].exp32);
    end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      int b;
      d = 8'($urandom_range(0, 255));
      b = $urandom_range(0, 1);
      cpu_write(ra(3, b), d);
      exp_rd($sformatf("rnd_imr_%0d", i), ra(3, b), d);
    end

    // 1: single source, vector and in-service
    do_reset();
    cpu_write(ra(0, 1), 8'h20);
    cpu_write(ra(3, 1), 8'h20);
    cpu_write(ra(6, 0), 8'h48);
    irq_in[13] = 1'b1;
    tick(1);
    irq_in[13] = 1'b0;
    tick(2);
    exp_val("t1_irq_early", {7'b0, irq}, 8'h00);
    tick(1);
    exp_val("t1_irq", {7'b0, irq}, 8'h01);
    exp_rd("t1_stat", ra(7, 0), 8'h8D);
    iack = 1'b1;
    tick(1);
    exp_val("t1_vec", dout, 8'h4D);
    tick(1);
    exp_val("t1_vec_hold", dout, 8'h4D);
    exp_val("t1_irq_off", {7'b0, irq}, 8'h00);
    iack = 1'b0;
    tick(1);
    exp_val("t1_dout_idle", dout, 8'h00);
    exp_rd("t1_ipr1", ra(1, 1), 8'h00);
    exp_rd("t1_isr1", ra(2, 1), 8'h20);

    // 2: lower priority blocked by in-service, released by ISR write
    cpu_write(ra(0, 0), 8'h10);
    cpu_write(ra(3, 0), 8'h10);
    irq_in[4] = 1'b1;
    tick(1);
    irq_in[4] = 1'b0;
    tick(4);
    exp_rd("t2_ipr0", ra(1, 0), 8'h10);
    exp_val("t2_irq_blocked", {7'b0, irq}, 8'h00);
    cpu_write(ra(2, 1), 8'hDF);
    exp_val("t2_irq_same", {7'b0, irq}, 8'h00);
    tick(1);
    exp_val("t2_irq_next", {7'b0, irq}, 8'h01);
    iack = 1'b1;
    tick(1);
    exp_val("t2_vec", dout, 8'h44);
    iack = 1'b0;
    tick(1);
    exp_rd("t2_isr0", ra(2, 0), 8'h10);
    cpu_write(ra(6, 0), 8'h40);
    exp_rd("t2_vr_eoi", ra(2, 0), 8'h00);
    cpu_write(ra(6, 0), 8'h48);

    // 3: level mode re-asserts after iack
    cpu_write(ra(5, 0), 8'h40);
    cpu_write(ra(0, 0), 8'h50);
    cpu_write(ra(3, 0), 8'h50);
    irq_in[6] = 1'b1;
    tick(4);
    exp_rd("t3_ipr_set", ra(1, 0), 8'h40);
    exp_val("t3_irq", {7'b0, irq}, 8'h01);
    iack = 1'b1;
    tick(1);
    exp_val("t3_vec", dout, 8'h46);
    tick(1);
    exp_rd("t3_ipr_again", ra(1, 0), 8'h40);
    iack = 1'b0;
    tick(1);
    exp_rd("t3_isr", ra(2, 0), 8'h40);
    irq_in[6] = 1'b0;
    tick(3);
    cpu_write(ra(1, 0), 8'hBF);
    exp_rd("t3_ipr_clr", ra(1, 0), 8'h00);
    tick(3);
    exp_rd("t3_ipr_stays", ra(1, 0), 8'h00);
    cpu_write(ra(5, 0), 8'h00);
    cpu_write(ra(6, 0), 8'h40);
    cpu_write(ra(6, 0), 8'h48);
    cpu_write(ra(0, 0), 8'h00);
    cpu_write(ra(3, 0), 8'h00);

    // 4: AER inverts, falling input edge sets IPR
    irq_in[5] = 1'b1;
    cpu_write(ra(4, 0), 8'h20);
    tick(4);
    cpu_write(ra(0, 0), 8'h20);
    cpu_write(ra(3, 0), 8'h20);
    irq_in[5] = 1'b0;
    tick(4);
    exp_rd("t4_fall_sets", ra(1, 0), 8'h20);
    cpu_write(ra(1, 0), 8'hDF);
    exp_rd("t4_clr", ra(1, 0), 8'h00);
    irq_in[5] = 1'b1;
    tick(4);
    exp_rd("t4_rise_no_set", ra(1, 0), 8'h00);
    cpu_write(ra(0, 0), 8'h00);
    cpu_write(ra(3, 0), 8'h00);
    cpu_write(ra(4, 0), 8'h00);
    irq_in[5] = 1'b0;
    tick(3);

    // 5: spurious vector, set beats same-edge clear
    iack = 1'b1;
    tick(1);
    exp_val("t5_spurious", dout, 8'h18);
    iack = 1'b0;
    tick(1);
    exp_rd("t5_ipr0", ra(1, 0), 8'h00);
    exp_rd("t5_isr0", ra(2, 0), 8'h00);
    exp_rd("t5_isr1", ra(2, 1), 8'h00);
    cpu_write(ra(0, 1), 8'h01);
    irq_in[8] = 1'b1;
    tick(1);
    irq_in[8] = 1'b0;
    tick(1);
    cpu_write(ra(1, 1), 8'h00);
    exp_rd("t5_set_beats_clr", ra(1, 1), 8'h01);

    // reset asserted mid-iack, iack held through release
    cpu_write(ra(3, 1), 8'h01);
    iack = 1'b1;
    tick(1);
    exp_val("rst_iack_vec", dout, 8'h48);
    reset_n = 1'b0;
    tick(1);
    exp_val("rst_iack_dout", dout, 8'h00);
    reset_n = 1'b1;
    tick(3);
    exp_val("rst_iack_no_reack", dout, 8'h00);
    exp_val("rst_iack_irq", {7'b0, irq}, 8'h00);
    iack = 1'b0;
    tick(1);

    // 6: 32-source instance, top bank and vector
    do_reset();
    cpu_write(ra(6, 0), 8'h60);
    cpu_write(ra(0, 3), 8'h80);
    cpu_write(ra(3, 3), 8'h80);
    exp_rd32("t6_ier3_32", ra(0, 3), 8'h80);
    exp_rd("t6_ier3_16", ra(0, 3), 8'h00);
    cpu_write(ra(0, 2), 8'hFF);
    exp_rd("t6_ier2_16", ra(0, 2), 8'h00);
    exp_rd32("t6_ier2_32", ra(0, 2), 8'hFF);
    irq_in32[31] = 1'b1;
    tick(1);
    irq_in32[31] = 1'b0;
    tick(3);
    exp_val("t6_irq32", {7'b0, irq32}, 8'h01);
    iack = 1'b1;
    tick(1);
    exp_val("t6_vec32", dout32, 8'h7F);
    iack = 1'b0;
    tick(1);
    exp_rd32("t6_isr3_32", ra(2, 3), 8'h00);
    exp_rd32("t6_ipr3_32", ra(1, 3), 8'h00);
    exp_val("t6_irq32_off", {7'b0, irq32}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
